mem_bus_arbiter: RTL

- Shares the single-port data memory/IO bus between two masters: M0 is the CPU data port, M1 is a secondary master (debug/boot loader).
- Sits between the masters and the slave bus that feeds the IO block and data RAM.
- Serialises accesses with a round-robin grant and sequences each access: address/data issue, fixed read-latency wait, acknowledge.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: master-side request/ack signals plus slave-side bus of the arbiter
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m_rdata;
    logic          s_en;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic          busy;
    logic          grant_id;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output s_rdata,
        input  m0_ack, m1_ack, m_rdata,
        input  s_en, s_we, s_addr, s_wdata,
        input  busy, grant_id
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  s_rdata,
        output m0_ack, m1_ack, m_rdata,
        output s_en, s_we, s_addr, s_wdata,
        output busy, grant_id
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the data memory/IO bus between two masters
module mem_bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input logic            clk,
    input logic            sys_rst_n,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          sel;

    // Next state: pick a master in IDLE, latch its access, sequence issue/wait/ack
    always_comb begin
        sel     = (bus.m0_req && bus.m1_req) ? ptr_q : bus.m1_req;
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.m0_req || bus.m1_req) begin
                state_d = ISSUE;
                gnt_d   = sel;
                we_d    = sel ? bus.m1_we : bus.m0_we;
                addr_d  = sel ? bus.m1_addr : bus.m0_addr;
                wdata_d = sel ? bus.m1_wdata : bus.m0_wdata;
            end
            ISSUE: begin
                state_d = we_q ? ACK : WAIT;
                cnt_d   = we_q ? cnt_q : 4'(RD_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = bus.s_rdata;
                    state_d = ACK;
                end
            end
            default: begin
                ptr_d   = ~gnt_q;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; async reset abandons any in-flight access
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s_en     = state_q == ISSUE;
    assign bus.s_we     = we_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.m_rdata  = rdata_q;
    assign bus.m0_ack   = (state_q == ACK) && !gnt_q;
    assign bus.m1_ack   = (state_q == ACK) && gnt_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.grant_id = gnt_q;
endmodule
